// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory/peripheral bus arbiter: FSM states,
// address map and the chip-select bundle used by the decoder and the DMA engine.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic blk;
        logic kbd;
        logic vhd;
    } cs_t;

    localparam logic [31:0] BLK_END        = 32'h0000_5000;
    localparam logic [31:0] KBD_ADDR       = 32'h0000_5000;
    localparam logic [31:0] VHD_BASE       = 32'h0000_50FC;
    localparam logic [31:0] VHD_END        = 32'h0000_5200;
    localparam int          TIMEOUT_CYCLES = 1024;
    localparam logic [9:0]  TIMER_LAST     = 10'(TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/mem_bus_arbiter_decoder.sv
// Combinational address decoder producing at most one chip select.
// Keyboard wins over block RAM; 0x5001..0x50FB and >= VHD_END stay unmapped.
module mem_addr_decoder
    import mem_bus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    output cs_t         cs
);

    logic is_kbd;
    logic is_blk;
    logic is_vhd;

    assign is_kbd = (addr == KBD_ADDR);
    assign is_blk = !is_kbd && (addr < BLK_END);
    assign is_vhd = !is_kbd && !is_blk && (addr >= VHD_BASE) && (addr < VHD_END);

    assign cs = '{blk: is_blk, kbd: is_kbd, vhd: is_vhd};

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and bus sequencer (m0 = CPU, m1 = VHD DMA).
// Define BUS_TIMEOUT_EN to abort WAIT accesses after TIMEOUT_CYCLES as unmapped.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic        m0_half,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ok,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic        m1_half,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ok,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic        bus_re,
    output logic        bus_half,
    output logic [31:0] bus_wdata,
    output logic        cs_blk,
    output logic        cs_kbd,
    output logic        cs_vhd,
    input  logic        blk_ok,
    input  logic        vhd_ok,
    input  logic [31:0] blk_rdata,
    input  logic [15:0] kbd_rdata,
    input  logic [31:0] vhd_rdata,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_re_q, bus_re_d;
    logic        bus_half_q, bus_half_d;
    cs_t         cs_q, cs_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_ok_q, m0_ok_d;
    logic        m1_ok_q, m1_ok_d;
    logic        bus_err_q, bus_err_d;

    logic        sel_m1;
    logic [31:0] req_addr;
    cs_t         dec_cs;
    logic        slave_done;
    logic        unmapped;
    logic        timed_out;
    logic        complete;
    logic [31:0] rdata_sel;

    // On a tie last_grant_q decides: m1 only wins if m0 was served last.
    assign sel_m1   = m1_req & (~m0_req | ~last_grant_q);
    assign req_addr = sel_m1 ? m1_addr : m0_addr;

    mem_addr_decoder u_dec (
        .addr (req_addr),
        .cs   (dec_cs)
    );

    assign slave_done = (cs_q.blk & blk_ok) | (cs_q.vhd & vhd_ok) | cs_q.kbd;
    assign unmapped   = (cs_q == '0);

`ifdef BUS_TIMEOUT_EN
    logic [9:0] timer_q, timer_d;

    assign timer_d   = (state_q == WAIT) ? timer_q + 10'd1 : 10'd0;
    assign timed_out = (timer_q == TIMER_LAST) & ~slave_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= 10'd0;
        else     timer_q <= timer_d;
    end
`else
    assign timed_out = 1'b0;
`endif

    assign complete = slave_done | unmapped | timed_out;

    always_comb begin
        rdata_sel = 32'h0;
        if (!bus_we_q && !timed_out) begin
            if (cs_q.kbd)      rdata_sel = {16'h0, kbd_rdata};
            else if (cs_q.blk) rdata_sel = blk_rdata;
            else if (cs_q.vhd) rdata_sel = vhd_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_we_d     = bus_we_q;
        bus_re_d     = bus_re_q;
        bus_half_d   = bus_half_q;
        cs_d         = cs_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ok_d      = 1'b0;
        m1_ok_d      = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = sel_m1;
                    last_grant_d = sel_m1;
                    bus_addr_d   = req_addr;
                    bus_wdata_d  = sel_m1 ? m1_wdata : m0_wdata;
                    bus_half_d   = sel_m1 ? m1_half  : m0_half;
                    bus_we_d     = sel_m1 ? m1_we    : m0_we;
                    bus_re_d     = ~bus_we_d;
                    cs_d         = dec_cs;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (complete) begin
                    if (grant_q) begin
                        m1_rdata_d = rdata_sel;
                        m1_ok_d    = 1'b1;
                    end else begin
                        m0_rdata_d = rdata_sel;
                        m0_ok_d    = 1'b1;
                    end
                    bus_err_d = unmapped | timed_out;
                    bus_we_d  = 1'b0;
                    bus_re_d  = 1'b0;
                    cs_d      = '0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_we_q     <= 1'b0;
            bus_re_q     <= 1'b0;
            bus_half_q   <= 1'b0;
            cs_q         <= '0;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
            m0_ok_q      <= 1'b0;
            m1_ok_q      <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_we_q     <= bus_we_d;
            bus_re_q     <= bus_re_d;
            bus_half_q   <= bus_half_d;
            cs_q         <= cs_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ok_q      <= m0_ok_d;
            m1_ok_q      <= m1_ok_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ok     = m0_ok_q;
    assign m1_ok     = m1_ok_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign bus_half  = bus_half_q;
    assign cs_blk    = cs_q.blk;
    assign cs_kbd    = cs_q.kbd;
    assign cs_vhd    = cs_q.vhd;
    assign bus_err   = bus_err_q;

endmodule
